// File: rtl/enc_pkg.sv
// Shared encoder definitions: hypervector geometry, pack sizing and the
// pack sequencer state encoding.
package enc_pkg;

   localparam int HV_DIM            = 10000;
   localparam int SHIFTS            = 10;
   localparam int PACK_WIDTH        = 10;
   localparam int DEFAULT_NUM_PACKS = 40;

   // Wide enough for BIND_LATENCY-1 with BIND_LATENCY up to 15
   localparam int WAIT_W = 4;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_ISSUE,
      SEQ_WAIT,
      SEQ_OUT,
      SEQ_DONE
   } seq_state_e;

endpackage

// File: rtl/enc_seq_wait_timer.sv
// Down-counter that times the binder latency between a pack's start strobe
// and its shifted hypervector becoming valid.
module enc_seq_wait_timer
   import enc_pkg::*;
(
   input  logic              clk,
   input  logic              nrst,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic              dec_i,
   input  logic [WAIT_W-1:0] load_val_i,
   output logic              expire_o
);

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   // Clear wins over load, load wins over decrement; the count never underflows
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WAIT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The last waiting cycle is the one in which the count reads one
   assign expire_o = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/enc_pack_sequencer.sv
// Sequences NUM_PACKS binder packs: strobes each pack, waits the binder
// latency, presents the result to the bundler and advances on acceptance.
// Optional macro ENC_SEQ_PERF_EN adds pass_cycles/stall_cycles counters.
module enc_pack_sequencer
   import enc_pkg::*;
#(
   parameter int NUM_PACKS    = DEFAULT_NUM_PACKS,
   parameter int BIND_LATENCY = 1
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         start,
   input  logic                         abort,
   output logic [NUM_PACKS-1:0]         pack_start,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(NUM_PACKS)-1:0] out_pack_idx,
   output logic                         busy,
`ifdef ENC_SEQ_PERF_EN
   output logic                         done,
   output logic [15:0]                  pass_cycles,
   output logic [15:0]                  stall_cycles
`else
   output logic                         done
`endif
);

   localparam int                IDX_W    = $clog2(NUM_PACKS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PACKS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(BIND_LATENCY - 1);

   seq_state_e           state_q;
   seq_state_e           state_d;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_d;
   logic [NUM_PACKS-1:0] pack_start_q;
   logic [NUM_PACKS-1:0] pack_start_d;
   logic                 out_valid_q;
   logic [IDX_W-1:0]     out_pack_idx_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 timerExpire;
   logic                 startAccept;

   assign startAccept = (state_q == SEQ_IDLE) && start && !abort;

   enc_seq_wait_timer u_wait_timer (
      .clk        (clk),
      .nrst       (nrst),
      .clear_i    (abort),
      .load_i     (state_q == SEQ_ISSUE),
      .dec_i      (state_q == SEQ_WAIT),
      .load_val_i (WAIT_LD),
      .expire_o   (timerExpire)
   );

   // Next state and pack index; abort overrides every transition
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (abort) begin
         state_d = SEQ_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               if (start) begin
                  state_d = SEQ_ISSUE;
                  idx_d   = '0;
               end
            end
            SEQ_ISSUE: begin
               state_d = (BIND_LATENCY > 1) ? SEQ_WAIT : SEQ_OUT;
            end
            SEQ_WAIT: begin
               if (timerExpire) begin
                  state_d = SEQ_OUT;
               end
            end
            SEQ_OUT: begin
               if (out_ready) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = SEQ_DONE;
                  end else begin
                     state_d = SEQ_ISSUE;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end
            end
            SEQ_DONE: begin
               state_d = SEQ_IDLE;
            end
            default: begin
               state_d = SEQ_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   // One-hot start strobe for the pack about to be issued
   always_comb begin
      pack_start_d = '0;
      if (state_d == SEQ_ISSUE) begin
         pack_start_d[idx_d] = 1'b1;
      end
   end

   // State and pack index registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= SEQ_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pack_start_q   <= '0;
         out_valid_q    <= 1'b0;
         out_pack_idx_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         pack_start_q   <= pack_start_d;
         out_valid_q    <= (state_d == SEQ_OUT);
         out_pack_idx_q <= idx_d;
         busy_q         <= (state_d != SEQ_IDLE);
         done_q         <= (state_d == SEQ_DONE);
      end
   end

   assign pack_start   = pack_start_q;
   assign out_valid    = out_valid_q;
   assign out_pack_idx = out_pack_idx_q;
   assign busy         = busy_q;
   assign done         = done_q;

`ifdef ENC_SEQ_PERF_EN
   logic [15:0] pass_cycles_q;
   logic [15:0] stall_cycles_q;

   // Saturating busy and stall counters, cleared when a new pass is accepted
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pass_cycles_q  <= '0;
         stall_cycles_q <= '0;
      end else if (startAccept) begin
         pass_cycles_q  <= '0;
         stall_cycles_q <= '0;
      end else begin
         if (busy_q && (pass_cycles_q != 16'hFFFF)) begin
            pass_cycles_q <= pass_cycles_q + 16'd1;
         end
         if (out_valid_q && !out_ready && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end
      end
   end

   assign pass_cycles  = pass_cycles_q;
   assign stall_cycles = stall_cycles_q;
`else
   logic unusedStart;
   assign unusedStart = startAccept;
`endif

endmodule

// File: tb/tb_enc_pack_sequencer.sv
// Scoreboard bench for enc_pack_sequencer (4 packs, binder latency 3).
// The reference model tracks each pass as a pack number and the age in
// cycles since that pack was strobed; outputs follow from those numbers.
module tb_enc_pack_sequencer;

   localparam int NP = 4;
   localparam int BL = 3;

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic          abort;
   logic          out_ready;
   logic [NP-1:0] pack_start;
   logic          out_valid;
   logic [1:0]    out_pack_idx;
   logic          busy;
   logic          done;
`ifdef ENC_SEQ_PERF_EN
   logic [15:0]   pass_cycles;
   logic [15:0]   stall_cycles;
`endif

   typedef struct packed {
      logic [NP-1:0] ps;
      logic          valid;
      logic [1:0]    idx;
      logic          busy;
      logic          done;
      logic [15:0]   passCyc;
      logic [15:0]   stallCyc;
   } expect_t;

   expect_t expQ[$];
   int      total = 0;
   int      bad = 0;
   int      modelDones = 0;
   int      dutDones = 0;

   bit      mInPass;
   bit      mDone;
   int      mPack;
   int      mAge;
   int      mPassCyc;
   int      mStallCyc;

   always #5 clk = ~clk;

   enc_pack_sequencer #(
      .NUM_PACKS    (NP),
      .BIND_LATENCY (BL)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .abort        (abort),
      .pack_start   (pack_start),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pack_idx (out_pack_idx),
      .busy         (busy),
`ifdef ENC_SEQ_PERF_EN
      .done         (done),
      .pass_cycles  (pass_cycles),
      .stall_cycles (stall_cycles)
`else
      .done         (done)
`endif
   );

   function automatic expect_t modelOutputs();
      expect_t e;
      e.ps       = (mInPass && mAge == 0) ? (NP'(1) << mPack) : '0;
      e.valid    = mInPass && (mAge >= BL);
      e.idx      = 2'(mPack);
      e.busy     = mInPass || mDone;
      e.done     = mDone;
      e.passCyc  = 16'(mPassCyc);
      e.stallCyc = 16'(mStallCyc);
      return e;
   endfunction

   function automatic void modelReset();
      mInPass   = 0;
      mDone     = 0;
      mPack     = 0;
      mAge      = 0;
      mPassCyc  = 0;
      mStallCyc = 0;
   endfunction

   // Advance the model across one clock edge given the inputs sampled there
   function automatic void modelAdvance(input logic s, input logic a, input logic r);
      bit idle;
      bit valid;
      idle  = !mInPass && !mDone;
      valid = mInPass && (mAge >= BL);
      if (!a && idle && s) begin
         mPassCyc  = 0;
         mStallCyc = 0;
      end else begin
         if ((mInPass || mDone) && mPassCyc < 65535) mPassCyc++;
         if (valid && !r && mStallCyc < 65535) mStallCyc++;
      end
      if (a) begin
         mInPass = 0;
         mDone   = 0;
         mPack   = 0;
         mAge    = 0;
      end else if (mDone) begin
         mDone = 0;
      end else if (!mInPass) begin
         if (s) begin
            mInPass = 1;
            mPack   = 0;
            mAge    = 0;
         end
      end else if (valid && r) begin
         if (mPack == NP - 1) begin
            mInPass = 0;
            mDone   = 1;
            modelDones++;
         end else begin
            mPack++;
            mAge = 0;
         end
      end else begin
         mAge++;
      end
   endfunction

   task automatic checkOutput(input string name, input expect_t e);
      bit ok;
      total++;
      ok = (pack_start === e.ps) && (out_valid === e.valid) && (out_pack_idx === e.idx)
           && (busy === e.busy) && (done === e.done);
`ifdef ENC_SEQ_PERF_EN
      ok = ok && (pass_cycles === e.passCyc) && (stall_cycles === e.stallCyc);
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s t=%0t got ps=%b v=%b idx=%0d busy=%b done=%b pass=%0d stall=%0d want ps=%b v=%b idx=%0d busy=%b done=%b pass=%0d stall=%0d",
                  name, $time, pack_start, out_valid, out_pack_idx, busy, done, pass_cycles, stall_cycles,
                  e.ps, e.valid, e.idx, e.busy, e.done, e.passCyc, e.stallCyc);
      end
`else
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s t=%0t got ps=%b v=%b idx=%0d busy=%b done=%b want ps=%b v=%b idx=%0d busy=%b done=%b",
                  name, $time, pack_start, out_valid, out_pack_idx, busy, done,
                  e.ps, e.valid, e.idx, e.busy, e.done);
      end
`endif
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the edge
   task automatic applyStimulus(input logic s, input logic a, input logic r);
      @(negedge clk);
      start     = s;
      abort     = a;
      out_ready = r;
      modelAdvance(s, a, r);
      expQ.push_back(modelOutputs());
   endtask

   // Asynchronous reset landing mid-cycle, checked before any further edge
   task automatic pulseReset();
      @(posedge clk);
      #3;
      nrst = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset", modelOutputs());
      @(negedge clk);
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      expQ.push_back(modelOutputs());
      @(posedge clk);
      #2;
      nrst = 1'b1;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n;
      n = 0;
      while ((mInPass || mDone) && n < budget) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         n++;
      end
      if (mInPass || mDone) begin
         total++;
         bad++;
         $display("[TB] FAIL %s timeout after %0d cycles, required idle", name, budget);
      end
   endtask

   // Monitor: compare every presented cycle against the queued expectation
   always @(posedge clk) begin
      expect_t e;
      #1;
      if (done === 1'b1) dutDones++;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("cycle", e);
      end
   end

   initial begin
      int stallLeft;
      int n;
      int d0;
      bit r;

      nrst      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      modelReset();
      #1;
      checkOutput("reset_state", modelOutputs());
      @(posedge clk);
      #2;
      nrst = 1'b1;

      $display("[TB] full pass with ready tied high");
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitIdle("pass_ready", 100);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] stall of 5 cycles on pack 2");
      applyStimulus(1'b1, 1'b0, 1'b1);
      stallLeft = 5;
      n = 0;
      while ((mInPass || mDone) && n < 200) begin
         r = 1'b1;
         if (mInPass && mPack == 2 && mAge >= BL && stallLeft > 0) begin
            r = 1'b0;
            stallLeft--;
         end
         applyStimulus(1'b0, 1'b0, r);
         n++;
      end
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef ENC_SEQ_PERF_EN
      total++;
      if (stall_cycles !== 16'd5) begin
         bad++;
         $display("[TB] FAIL stall_count got %0d want 5", stall_cycles);
      end
`endif

      $display("[TB] abort on the pack 3 handshake");
      applyStimulus(1'b1, 1'b0, 1'b1);
      n = 0;
      while (!(mInPass && mPack == 3 && mAge >= BL) && n < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         n++;
      end
      applyStimulus(1'b0, 1'b1, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitIdle("restart_after_abort", 100);

      $display("[TB] reset during WAIT of pack 1");
      applyStimulus(1'b1, 1'b0, 1'b1);
      n = 0;
      while (!(mInPass && mPack == 1 && mAge == 1) && n < 100) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         n++;
      end
      pulseReset();
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] start held through busy and done");
      d0 = dutDones;
      applyStimulus(1'b1, 1'b0, 1'b1);
      n = 0;
      while ((mInPass || mDone) && n < 200) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         n++;
      end
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      total++;
      if (dutDones - d0 != 1) begin
         bad++;
         $display("[TB] FAIL one_done_per_start got %0d pulses want 1", dutDones - d0);
      end

      $display("[TB] randomized traffic");
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulseReset();
         end else begin
            applyStimulus($urandom_range(0, 9) < 2, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) < 6);
         end
      end
      waitIdle("drain", 200);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #2;

      total++;
      if (dutDones != modelDones) begin
         bad++;
         $display("[TB] FAIL done_count got %0d want %0d", dutDones, modelDones);
      end
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL queue_drain got %0d left want 0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/enc_pack_sequencer.md
ENC_PACK_SEQUENCER -- requirements
Module: enc_pack_sequencer

Interface
REQ-001 Parameter NUM_PACKS, default 40, number of binder packs sequenced (10 binders each, pack p drives features 10p..10p+9).
REQ-002 Parameter BIND_LATENCY, default 1, cycles from a pack's start_encoding to valid shifted_hv; legal range 1..15.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 nrst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one full encoding pass; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of the current pass.
REQ-007 pack_start  output  NUM_PACKS  one-hot start_encoding strobe, bit p to pack p.
REQ-008 out_valid  output  1  shifted_hv of pack out_pack_idx is valid for the bundler.
REQ-009 out_ready  input  1  bundler accepts the current pack.
REQ-010 out_pack_idx  output  $clog2(NUM_PACKS)  index of the pack being presented.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the last pack is accepted.

Function
REQ-013 States: IDLE, ISSUE, WAIT, OUT, DONE; all outputs registered.
REQ-014 IDLE: start=1 at edge k -> ISSUE in cycle k+1 with pack_idx=0; start in other states is ignored, not queued.
REQ-015 ISSUE: pack_start bit pack_idx high for exactly one cycle; next state WAIT if BIND_LATENCY>1, else OUT.
REQ-016 WAIT: lasts BIND_LATENCY-1 cycles via down-counter, then OUT; out_valid rises exactly BIND_LATENCY cycles after the pack_start pulse.
REQ-017 OUT: out_valid held high and out_pack_idx stable until out_valid&&out_ready.
REQ-018 On handshake: if pack_idx==NUM_PACKS-1 -> DONE, else pack_idx+1 and ISSUE in the next cycle.
REQ-019 DONE: done=1 for one cycle, then IDLE; a start asserted during DONE is ignored.
REQ-020 With out_ready tied high, a pass takes NUM_PACKS*(BIND_LATENCY+1) cycles from first pack_start to the last handshake; done follows one cycle later.
REQ-021 pack_idx never wraps; it is not incremented beyond NUM_PACKS-1.
REQ-022 abort=1 in any state -> IDLE next cycle; pack_start, out_valid, done low; no done pulse; abort has priority over the handshake and over start.
REQ-023 At most one pack_start bit is high in any cycle; pack_start is all-zero outside ISSUE.

Reset
REQ-024 nrst low asynchronously forces IDLE, pack_idx=0, wait counter=0, pack_start=0, out_valid=0, out_pack_idx=0, busy=0, done=0.
REQ-025 nrst asserted mid-pass discards the pass; after release the block waits in IDLE for a new start.

Configuration
REQ-026 Macro ENC_SEQ_PERF_EN defined: adds outputs pass_cycles[15:0] (cycles busy in the current/last pass, saturating at 16'hFFFF) and stall_cycles[15:0] (cycles with out_valid&&!out_ready, saturating); both clear on accepted start and reset; both hold after done.
REQ-027 Macro undefined: these ports and counters do not exist; all other behaviour is identical.

Structure
REQ-028 Shared package enc_pkg holds HV_DIM, SHIFTS, PACK_WIDTH=10, the default NUM_PACKS and the sequencer state enum.
REQ-029 One sub-module, enc_seq_wait_timer (load BIND_LATENCY-1, decrement, expire flag), instantiated once.

Verification
REQ-030 NUM_PACKS=4, BIND_LATENCY=1, out_ready=1, start pulse at cycle 0 -> pack_start = 0001, 0010, 0100, 1000 at cycles 1, 3, 5, 7; out_valid at cycles 2, 4, 6, 8; done at cycle 9; busy high in cycles 1..9.
REQ-031 BIND_LATENCY=3 -> out_valid rises exactly 3 cycles after each pack_start; the pass of 4 packs spans 16 cycles.
REQ-032 out_ready low for 5 cycles on pack 2 -> out_valid and out_pack_idx=2 held stable; no pack_start issued during the stall; with ENC_SEQ_PERF_EN, stall_cycles=5.
REQ-033 abort asserted in the same cycle as the pack-3 handshake -> IDLE next cycle; no done pulse; a new start restarts from pack 0.
REQ-034 nrst pulsed during WAIT of pack 1 -> all outputs 0 immediately; start repeated during busy and during DONE is ignored (exactly one done per accepted start).
